// File: rtl/rv32_mod_alu_mc.sv
// rv32_mod_alu_mc: execute-stage ALU with single-cycle RV32I ops and an iterative RV32M multiplier.
// Define ALU_MULDIV_DIV_EN to build the iterative divider for DIV/DIVU/REM/REMU.
module rv32_mod_alu_mc #(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      func,
    input  logic [XLEN-1:0] read0_data,
    input  logic [XLEN-1:0] read1_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);
    localparam int NSTEP = XLEN / STEP_BITS;
    localparam int CW    = $clog2(NSTEP) + 1;
    localparam int SW    = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state;
    logic [CW-1:0]     step_cnt;
    logic [1:0]        op_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc, mcand, acc_nx, prod_nx;
    logic [XLEN-1:0]   mplier, mag_a, mag_b, done_res;
    logic              accept, a_sgn, b_sgn, a_neg, b_neg, last_step;

    function automatic logic [XLEN-1:0] base_op(input logic [3:0] key,
                                                input logic [XLEN-1:0] a, b);
        logic signed [XLEN-1:0] sa, sb;
        logic [SW-1:0]          shamt;
        sa    = a;
        sb    = b;
        shamt = b[SW-1:0];
        case (key)
            4'b0000: base_op = a + b;
            4'b1000: base_op = a - b;
            4'b0001: base_op = a << shamt;
            4'b0010: base_op = XLEN'(sa < sb);
            4'b0011: base_op = XLEN'(a < b);
            4'b0100: base_op = a ^ b;
            4'b0101: base_op = a >> shamt;
            4'b1101: base_op = sa >>> shamt;
            4'b0110: base_op = a | b;
            4'b0111: base_op = a & b;
            default: base_op = a;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        cond_neg = neg ? -v : v;
    endfunction

    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_step = (step_cnt == CW'(NSTEP - 1));

    // Signedness: MULH is s*s, MULHSU s*u, MUL/MULHU u*u; DIV/REM signed, DIVU/REMU unsigned.
    assign a_sgn = func[2] ? !func[0] : (func[1:0] == 2'b01 || func[1:0] == 2'b10);
    assign b_sgn = func[2] ? !func[0] : (func[1:0] == 2'b01);
    assign a_neg = a_sgn && read0_data[XLEN-1];
    assign b_neg = b_sgn && read1_data[XLEN-1];
    assign mag_a = cond_neg(a_neg, read0_data);
    assign mag_b = cond_neg(b_neg, read1_data);

    always_comb begin
        acc_nx = acc;
        for (int i = 0; i < STEP_BITS; i++)
            if (mplier[i]) acc_nx = acc_nx + (mcand << i);
    end
    assign prod_nx = neg_q ? -acc_nx : acc_nx;

`ifdef ALU_MULDIV_DIV_EN
    logic            neg_r, div_zero, div_ovf;
    logic [XLEN:0]   dv_part;
    logic [XLEN-1:0] dv_rem_nx, dv_quo_nx;

    assign div_zero = (read1_data == '0);
    assign div_ovf  = !func[0] && (read0_data == {1'b1, {(XLEN-1){1'b0}}}) && (read1_data == '1);

    // Restoring division: acc low half is the partial remainder, mplier shifts dividend out and quotient in.
    always_comb begin
        dv_rem_nx = acc[XLEN-1:0];
        dv_quo_nx = mplier;
        dv_part   = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            dv_part   = {dv_rem_nx, dv_quo_nx[XLEN-1]};
            dv_quo_nx = {dv_quo_nx[XLEN-2:0], 1'b0};
            if (dv_part >= {1'b0, mcand[XLEN-1:0]}) begin
                dv_part      = dv_part - {1'b0, mcand[XLEN-1:0]};
                dv_quo_nx[0] = 1'b1;
            end
            dv_rem_nx = dv_part[XLEN-1:0];
        end
    end
`endif

    always_comb begin
        done_res = (op_q == 2'b00) ? prod_nx[XLEN-1:0] : prod_nx[2*XLEN-1:XLEN];
`ifdef ALU_MULDIV_DIV_EN
        if (state == S_DIV)
            done_res = op_q[1] ? cond_neg(neg_r, dv_rem_nx) : cond_neg(neg_q, dv_quo_nx);
`endif
    end

    // Control: FSM, handshake and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            illegal   <= 1'b0;
            busy      <= 1'b0;
            step_cnt  <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    step_cnt <= '0;
                    illegal  <= 1'b0;
                    if (!func[3]) begin
                        result    <= base_op({func[4], func[2:0]}, read0_data, read1_data);
                        out_valid <= 1'b1;
                    end else if (!func[2]) begin
                        state <= S_MUL;
                        busy  <= 1'b1;
                    end
`ifdef ALU_MULDIV_DIV_EN
                    else if (div_zero) begin
                        result    <= func[1] ? read0_data : '1;
                        out_valid <= 1'b1;
                    end else if (div_ovf) begin
                        result    <= func[1] ? '0 : read0_data;
                        out_valid <= 1'b1;
                    end else begin
                        state <= S_DIV;
                        busy  <= 1'b1;
                    end
`else
                    else begin
                        result    <= '0;
                        illegal   <= 1'b1;
                        out_valid <= 1'b1;
                    end
`endif
                end
                S_MUL, S_DIV: begin
                    step_cnt <= step_cnt + CW'(1);
                    if (last_step) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        result    <= done_res;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: operand latch and iteration registers
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= func[1:0];
            neg_q  <= a_neg ^ b_neg;
            acc    <= '0;
            mplier <= mag_a;
            mcand  <= {{XLEN{1'b0}}, mag_b};
`ifdef ALU_MULDIV_DIV_EN
            neg_r  <= a_neg;
`endif
        end else if (state == S_MUL) begin
            acc    <= acc_nx;
            mcand  <= mcand << STEP_BITS;
            mplier <= mplier >> STEP_BITS;
        end
`ifdef ALU_MULDIV_DIV_EN
        else if (state == S_DIV) begin
            acc    <= {{XLEN{1'b0}}, dv_rem_nx};
            mplier <= dv_quo_nx;
        end
`endif
    end

endmodule

// File: tb/tb_rv32_mod_alu_mc.sv
// Self-checking bench for rv32_mod_alu_mc: directed cases, backpressure, reset abort, random ops vs a behavioural model.
module tb_rv32_mod_alu_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  func = 5'd0;
    logic [31:0] read0_data = 32'd0;
    logic [31:0] read1_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        illegal;
    logic        busy;

    logic        rand_rdy = 1'b0;
    logic        force_rdy = 1'b1;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] last_res = 32'd0;
    logic        last_ill = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          due;
        bit          iter;
    } exp_t;
    exp_t exp_q[$];

    rv32_mod_alu_mc #(.XLEN(32), .STEP_BITS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .func(func),
        .read0_data(read0_data), .read1_data(read1_data), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: {illegal, result} from plain 64-bit arithmetic.
    function automatic logic [32:0] model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (!f[3]) begin
            case ({f[4], f[2:0]})
                4'b0000: return {1'b0, a + b};
                4'b1000: return {1'b0, a - b};
                4'b0001: return {1'b0, 32'(ua << b[4:0])};
                4'b0010: return {1'b0, 32'(sa < sb)};
                4'b0011: return {1'b0, 32'(ua < ub)};
                4'b0100: return {1'b0, a ^ b};
                4'b0101: return {1'b0, 32'(ua >> b[4:0])};
                4'b1101: return {1'b0, 32'(sa >>> b[4:0])};
                4'b0110: return {1'b0, a | b};
                4'b0111: return {1'b0, a & b};
                default: return {1'b0, a};
            endcase
        end
        if (!f[2]) begin
            case (f[1:0])
                2'b00:   p = ua * ub;
                2'b01:   p = sa * sb;
                2'b10:   p = sa * ub;
                default: p = ua * ub;
            endcase
            return {1'b0, (f[1:0] == 2'b00) ? p[31:0] : p[63:32]};
        end
`ifdef ALU_MULDIV_DIV_EN
        if (b == 32'd0) return {1'b0, f[1] ? a : 32'hFFFF_FFFF};
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, f[1] ? 32'd0 : a};
            return {1'b0, f[1] ? 32'(sa % sb) : 32'(sa / sb)};
        end
        return {1'b0, f[1] ? a % b : a / b};
`else
        return {1'b1, 32'd0};
`endif
    endfunction

    function automatic int lat(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[3]) return 1;
        if (!f[2]) return 33;
`ifdef ALU_MULDIV_DIV_EN
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        return 1;
`endif
    endfunction

    // Compare process: sampled mid-cycle, scoreboard of expected results in accept order.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && exp_q[0].iter && cyc < exp_q[0].due) begin
                chk("busy_during_iter", busy === 1'b1, 64'(busy), 64'd1);
                chk("in_ready_during_iter", in_ready === 1'b0, 64'(in_ready), 64'd0);
            end
            if (exp_q.size() > 0 && cyc == exp_q[0].due)
                chk("latency", out_valid === 1'b1, 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1'b0, 64'(result), 64'd0);
                end else begin
                    chk("result", result === exp_q[0].res && cyc >= exp_q[0].due,
                        64'(result), 64'(exp_q[0].res));
                    chk("illegal", illegal === exp_q[0].ill, 64'(illegal), 64'(exp_q[0].ill));
                    if (out_ready) begin
                        last_res = result;
                        last_ill = illegal;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                {e.ill, e.res} = model(func, read0_data, read1_data);
                e.due  = cyc + lat(func, read0_data, read1_data);
                e.iter = lat(func, read0_data, read1_data) > 1;
                exp_q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int acc_cyc);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        in_valid = 1'b1; func = f; read0_data = a; read1_data = b;
        while (!got && n < 300) begin
            @(negedge clk);
            got = in_ready;
            n++;
            @(posedge clk);
            #2;
        end
        acc_cyc = cyc;
        if (!got) chk("accept_timeout", 1'b0, 64'd0, 64'd1);
        in_valid = 1'b0;
        func = 5'($urandom());
        read0_data = $urandom();
        read1_data = $urandom();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 1'b0, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic directed(input string name, input logic [4:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input logic ei);
        int c;
        issue(f, a, b, c);
        drain();
        chk({name, "_res"}, last_res === er, 64'(last_res), 64'(er));
        chk({name, "_ill"}, last_ill === ei, 64'(last_ill), 64'(ei));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int c1, c2;
        logic [4:0] rf;
        logic [31:0] ra, rb;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("reset_out_valid", out_valid === 1'b0, 64'(out_valid), 64'd0);
        chk("reset_result", result === 32'd0, 64'(result), 64'd0);
        chk("reset_illegal", illegal === 1'b0, 64'(illegal), 64'd0);
        chk("reset_busy", busy === 1'b0, 64'(busy), 64'd0);
        chk("reset_in_ready", in_ready === 1'b1, 64'(in_ready), 64'd1);

        directed("add",   5'b00000, 32'd5,          32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
        directed("sra",   5'b10101, 32'h8000_0000,  32'h24,        32'hF800_0000, 1'b0);
        directed("srl",   5'b00101, 32'h8000_0000,  32'h24,        32'h0800_0000, 1'b0);
        directed("slt",   5'b00010, 32'hFFFF_FFFF,  32'd1,         32'd1,         1'b0);
        directed("sltu",  5'b00011, 32'hFFFF_FFFF,  32'd1,         32'd0,         1'b0);
        directed("mulh",  5'b01001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
        directed("mulhu", 5'b01011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        directed("mul",   5'b01000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0);
        directed("mul34", 5'b01000, 32'd3,          32'd4,         32'd12,        1'b0);
`ifdef ALU_MULDIV_DIV_EN
        directed("div_by0",  5'b01100, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0);
        directed("rem_by0",  5'b01110, 32'd7,         32'd0,         32'd7,         1'b0);
        directed("div_ovf",  5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        directed("rem_ovf",  5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);
        directed("div_neg",  5'b01100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        directed("rem_neg",  5'b01110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
        directed("divu",     5'b01101, 32'd9,         32'd3,         32'd3,         1'b0);
`else
        directed("divu_ill", 5'b01101, 32'd9,         32'd3,         32'd0,         1'b1);
`endif

        // Back-to-back base ops: accepts on consecutive cycles.
        issue(5'b00000, 32'd10, 32'd20, c1);
        issue(5'b00100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, c2);
        chk("back_to_back", c2 == c1 + 1, 64'(c2 - c1), 64'd1);
        drain();

        // Backpressure: result held while out_ready is low, next op taken on release.
        force_rdy = 1'b0;
        @(posedge clk);
        #2;
        issue(5'b00000, 32'd100, 32'd23, c1);
        in_valid = 1'b1; func = 5'b00110; read0_data = 32'h1200; read1_data = 32'h0034;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid === 1'b1, 64'(out_valid), 64'd1);
            chk("hold_result", result === 32'd123, 64'(result), 64'd123);
            chk("hold_in_ready", in_ready === 1'b0, 64'(in_ready), 64'd0);
        end
        force_rdy = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready === 1'b1, 64'(in_ready), 64'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        drain();
        chk("after_release", last_res === 32'h1234, 64'(last_res), 64'h1234);

        // Reset during MULHU discards it.
        issue(5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c1);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", out_valid === 1'b0, 64'(out_valid), 64'd0);
        chk("abort_busy", busy === 1'b0, 64'(busy), 64'd0);
        chk("abort_in_ready", in_ready === 1'b1, 64'(in_ready), 64'd1);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        chk("no_stale_result", out_valid === 1'b0, 64'(out_valid), 64'd0);

        // Random ops with random consumer backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rf = 5'($urandom());
            ra = pick();
            rb = pick();
            issue(rf, ra, rb, c1);
            if ($urandom_range(0, 7) == 0) drain();
        end
        rand_rdy = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, checks so far %0d", n_chk);
        $fatal(1, "watchdog expired");
    end
endmodule
